// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the maze logic.
// master drives the raw buttons; slave (the conditioner) returns the
// debounced levels and the one-cycle press/release pulses.
interface button_conditioner_if #(
  parameter int NUM_BTN = 5
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner for the maze game.
// Each button: two-flop synchroniser, counter debouncer, registered
// press/release pulses, and an optional hold-to-repeat FSM that keeps
// emitting press pulses while a direction is held.
//
// Repeat FSM states (one instance per button):
//   state      | meaning
//   REP_IDLE   | button released, or repeat disabled for this bit
//   REP_DELAY  | held; waiting REPEAT_DELAY cycles for the first repeat
//   REP_REPEAT | held; emitting a press every REPEAT_PERIOD cycles
module button_conditioner #(
  parameter int                 NUM_BTN         = 5,
  parameter int                 DEBOUNCE_CYCLES = 1_000_000,
  parameter int                 REPEAT_DELAY    = 50_000_000,
  parameter int                 REPEAT_PERIOD   = 15_000_000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 5'b01111
) (
  input logic                 clock,
  input logic                 reset_n,
  button_conditioner_if.slave buttons
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_DELAY  = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_t;

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;

  // Two-flop synchroniser for the asynchronous pins; only sync2 is used.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= buttons.btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic [DB_W-1:0]  db_cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             db_done;
    logic             rise;
    logic             fall;
    rep_state_t       state;
    rep_state_t       state_nxt;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_nxt;
    logic             rep_fire;

    // The debounced level is about to flip on this edge.
    assign db_done = (sync2[i] != level_q) && (db_cnt == DB_LAST);
    assign rise    = db_done && !level_q;
    assign fall    = db_done && level_q;

    // Debouncer: any sample matching the current level restarts the count.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (sync2[i] == level_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level_q <= ~level_q;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    // Repeat FSM state and interval counter.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        state   <= REP_IDLE;
        rep_cnt <= '0;
      end else begin
        state   <= state_nxt;
        rep_cnt <= rep_cnt_nxt;
      end
    end

    // Repeat FSM next state; a release always wins over a pending repeat
    // so no press can be reported on the release edge.
    always_comb begin
      state_nxt   = state;
      rep_cnt_nxt = rep_cnt;
      rep_fire    = 1'b0;
      case (state)
        REP_IDLE: begin
          rep_cnt_nxt = '0;
          if (rise && REPEAT_MASK[i]) begin
            state_nxt = REP_DELAY;
          end
        end
        REP_DELAY: begin
          if (fall) begin
            state_nxt   = REP_IDLE;
            rep_cnt_nxt = '0;
          end else if (rep_cnt == DELAY_LAST) begin
            rep_fire    = 1'b1;
            rep_cnt_nxt = '0;
            state_nxt   = REP_REPEAT;
          end else begin
            rep_cnt_nxt = rep_cnt + 1'b1;
          end
        end
        REP_REPEAT: begin
          if (fall) begin
            state_nxt   = REP_IDLE;
            rep_cnt_nxt = '0;
          end else if (rep_cnt == PERIOD_LAST) begin
            rep_fire    = 1'b1;
            rep_cnt_nxt = '0;
          end else begin
            rep_cnt_nxt = rep_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt   = REP_IDLE;
          rep_cnt_nxt = '0;
        end
      endcase
    end

    // Registered pulses, aligned with the edge on which the level flips.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= rise | rep_fire;
        release_q <= fall;
      end
    end

    assign buttons.btn_level[i]   = level_q;
    assign buttons.btn_press[i]   = press_q;
    assign buttons.btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short timing parameters. A behavioural
// model works from the sampled raw history: the level flips once the last
// DB synchronised samples all disagree with it, and press pulses fall on
// fixed offsets from the debounced rise.
module tb_button_conditioner;
  localparam int         NB   = 5;
  localparam int         DB   = 4;
  localparam int         RD   = 20;
  localparam int         RP   = 8;
  localparam logic [4:0] MASK = 5'b01111;
  localparam int         MAXE = 8000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  button_conditioner_if #(.NUM_BTN(NB)) ifc ();

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_MASK    (MASK)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .buttons(ifc)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  logic [NB-1:0] raw_h [MAXE];
  bit            rst_h [MAXE];
  logic [NB-1:0] s_h   [MAXE];
  logic [NB-1:0] lvl_h [MAXE];
  int            rise_at [NB];
  int            n_edge = 0;

  logic [NB-1:0] exp_level   = '0;
  logic [NB-1:0] exp_press   = '0;
  logic [NB-1:0] exp_release = '0;

  task automatic model_edge(input logic [NB-1:0] r, input logic rn);
    int n;
    int m;
    int k;
    bit flip;
    logic [NB-1:0] prev;
    logic [NB-1:0] nl;
    n = n_edge;
    if (n >= MAXE) begin
      $display("FAIL model_overflow edge %0d limit %0d", n, MAXE);
      $fatal(1, "model history exhausted");
    end
    raw_h[n] = r;
    rst_h[n] = !rn;
    if (!rn || n == 0) s_h[n] = '0;
    else if (rst_h[n-1]) s_h[n] = '0;
    else s_h[n] = raw_h[n-1];
    prev        = (n == 0) ? '0 : lvl_h[n-1];
    nl          = '0;
    exp_press   = '0;
    exp_release = '0;
    if (rn) begin
      for (int i = 0; i < NB; i++) begin
        flip = 1'b1;
        for (int j = 0; j < DB; j++) begin
          m = n - j;
          if (m < 1) flip = 1'b0;
          else if (rst_h[m] || s_h[m-1][i] == prev[i]) flip = 1'b0;
        end
        nl[i] = flip ? ~prev[i] : prev[i];
        if (nl[i] && !prev[i]) begin
          rise_at[i]   = n;
          exp_press[i] = 1'b1;
        end else if (nl[i] && prev[i]) begin
          k = n - rise_at[i];
          if (MASK[i] && k >= RD && ((k - RD) % RP) == 0) exp_press[i] = 1'b1;
        end
        if (!nl[i] && prev[i]) exp_release[i] = 1'b1;
      end
    end
    lvl_h[n]  = nl;
    exp_level = nl;
    n_edge++;
  endtask

  task automatic check_outputs();
    n_assert++;
    assert (ifc.btn_level === exp_level) else begin
      n_fail++;
      $error("FAIL level edge %0d: got %b expected %b", n_edge - 1, ifc.btn_level, exp_level);
    end
    n_assert++;
    assert (ifc.btn_press === exp_press) else begin
      n_fail++;
      $error("FAIL press edge %0d: got %b expected %b", n_edge - 1, ifc.btn_press, exp_press);
    end
    n_assert++;
    assert (ifc.btn_release === exp_release) else begin
      n_fail++;
      $error("FAIL release edge %0d: got %b expected %b", n_edge - 1, ifc.btn_release, exp_release);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [NB-1:0] r, input logic rn);
    ifc.btn_raw = r;
    reset_n     = rn;
    @(posedge clock);
    model_edge(r, rn);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic settle();
    for (int k = 0; k < 12; k++) step('0, 1'b1);
  endtask

  int            first_k;
  int            cnt_a;
  int            cnt_b;
  int            mism;
  int            t_rise;
  int            e_last;
  int            p_edge;
  bit            found;
  logic [NB-1:0] vec;
  logic [6:0]    bounce = 7'b1001011;
  int            offs [$];
  int            rel_offs [$];
  int            exp4 [6] = '{0, 20, 28, 36, 44, 52};
  int            hold_left [NB];
  logic [NB-1:0] rv = '0;

  initial begin
    ifc.btn_raw = '0;

    // Reset held with every button pressed, then released.
    for (int k = 0; k < 5; k++) step(5'b11111, 1'b0);
    first_k = -1;
    vec     = '0;
    cnt_a   = 0;
    for (int k = 0; k < 15; k++) begin
      step(5'b11111, 1'b1);
      if (ifc.btn_press != '0) cnt_a++;
      if (first_k < 0 && ifc.btn_level == 5'b11111) begin
        first_k = k;
        vec     = ifc.btn_press;
      end
    end
    check_val("t1_level_edge", first_k, DB + 1);
    check_val("t1_press_vec", int'(vec), 31);
    check_val("t1_press_cycles", cnt_a, 1);
    settle();

    // Bounce on U: 1,1,0,1,0,0,1 then stable high.
    cnt_a  = 0;
    cnt_b  = 0;
    p_edge = -1;
    e_last = -1;
    for (int idx = 0; idx < 7; idx++) begin
      step({4'b0000, bounce[idx]}, 1'b1);
      if (idx == 6) e_last = n_edge - 1;
      if (ifc.btn_press[0]) begin cnt_a++; p_edge = n_edge - 1; end
      if (ifc.btn_release[0]) cnt_b++;
    end
    for (int k = 0; k < 15; k++) begin
      step(5'b00001, 1'b1);
      if (ifc.btn_press[0]) begin cnt_a++; p_edge = n_edge - 1; end
      if (ifc.btn_release[0]) cnt_b++;
    end
    check_val("t2_press_count", cnt_a, 1);
    check_val("t2_press_delay", p_edge - e_last, DB + 1);
    check_val("t2_release_count", cnt_b, 0);
    settle();

    // Glitch on D shorter than the debounce window.
    cnt_a = 0;
    for (int k = 0; k < 18; k++) begin
      step((k < 3) ? 5'b00100 : 5'b00000, 1'b1);
      if (ifc.btn_level[2] || ifc.btn_press[2] || ifc.btn_release[2]) cnt_a++;
    end
    check_val("t3_activity", cnt_a, 0);
    settle();

    // Hold U: repeats at fixed offsets, release lands on a would-be repeat.
    found = 1'b0;
    offs.delete();
    rel_offs.delete();
    for (int k = 0; k < 20 && !found; k++) begin
      step(5'b00001, 1'b1);
      if (ifc.btn_level[0]) found = 1'b1;
    end
    check_val("t4_rise_found", int'(found), 1);
    t_rise = n_edge - 1;
    if (ifc.btn_press[0]) offs.push_back(0);
    for (int k = 0; k < 54; k++) begin
      step(5'b00001, 1'b1);
      if (ifc.btn_press[0]) offs.push_back(n_edge - 1 - t_rise);
    end
    for (int k = 0; k < 12; k++) begin
      step(5'b00000, 1'b1);
      if (ifc.btn_press[0]) offs.push_back(n_edge - 1 - t_rise);
      if (ifc.btn_release[0]) rel_offs.push_back(n_edge - 1 - t_rise);
    end
    check_val("t4_press_count", offs.size(), 6);
    for (int i = 0; i < 6; i++) check_val("t4_press_offset", (i < offs.size()) ? offs[i] : -1, exp4[i]);
    check_val("t4_release_count", rel_offs.size(), 1);
    check_val("t4_release_offset", (rel_offs.size() > 0) ? rel_offs[0] : -1, 60);
    settle();

    // Hold C: repeat disabled, single press and single release.
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 65; k++) begin
      step(5'b10000, 1'b1);
      if (ifc.btn_press[4]) cnt_a++;
    end
    for (int k = 0; k < 12; k++) begin
      step(5'b00000, 1'b1);
      if (ifc.btn_release[4]) cnt_b++;
    end
    check_val("t5_press_count", cnt_a, 1);
    check_val("t5_release_count", cnt_b, 1);
    settle();

    // U and R together: identical press and repeat timing.
    found = 1'b0;
    vec   = '0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(5'b00011, 1'b1);
      if (ifc.btn_level[0]) begin found = 1'b1; vec = ifc.btn_press; end
    end
    check_val("t6_press_pair", int'(vec[1:0]), 3);
    cnt_a = int'(vec[1]);
    mism  = 0;
    for (int k = 0; k < 40; k++) begin
      step(5'b00011, 1'b1);
      if (ifc.btn_press[0] != ifc.btn_press[1]) mism++;
      if (ifc.btn_press[1]) cnt_a++;
    end
    for (int k = 0; k < 12; k++) begin
      step(5'b00000, 1'b1);
      if (ifc.btn_press[0] != ifc.btn_press[1]) mism++;
      if (ifc.btn_release[0] != ifc.btn_release[1]) mism++;
    end
    check_val("t6_pair_mismatch", mism, 0);
    check_val("t6_r_press_count", cnt_a, 4);
    settle();

    // Random per-button hold lengths with occasional reset.
    for (int i = 0; i < NB; i++) hold_left[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold_left[i] == 0) begin
          rv[i]        = 1'($urandom_range(0, 1));
          hold_left[i] = $urandom_range(1, 40);
        end
        hold_left[i]--;
      end
      if ($urandom_range(0, 399) == 0) step(rv, 1'b0);
      else step(rv, 1'b1);
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
